// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns {a..g}, decoder codes, scan FSM states.
package sseg_pkg;

    localparam logic [6:0] SSEG_SEG_0     = 7'b0000001;
    localparam logic [6:0] SSEG_SEG_1     = 7'b1001111;
    localparam logic [6:0] SSEG_SEG_2     = 7'b0010010;
    localparam logic [6:0] SSEG_SEG_3     = 7'b0000110;
    localparam logic [6:0] SSEG_SEG_4     = 7'b1001100;
    localparam logic [6:0] SSEG_SEG_5     = 7'b0100100;
    localparam logic [6:0] SSEG_SEG_6     = 7'b0100000;
    localparam logic [6:0] SSEG_SEG_7     = 7'b0001111;
    localparam logic [6:0] SSEG_SEG_8     = 7'b0000000;
    localparam logic [6:0] SSEG_SEG_9     = 7'b0000100;
    localparam logic [6:0] SSEG_SEG_BLANK = 7'b1111111;

    localparam logic [3:0] SSEG_BLANK_CODE = 4'hF;
    localparam logic [3:0] SSEG_BAD_CODE   = 4'hE;

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLE   = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational inverse of the display encoder: active-low cathode byte -> BCD code, dp, invalid flag.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [7:0] cathode,
    output logic [3:0] code,
    output logic       dp,
    output logic       invalid
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        code    = SSEG_BAD_CODE;
        invalid = 1'b1;
        dp      = ~cathode[0];
        case (cathode[7:1])
            SSEG_SEG_0:     begin code = 4'd0;            invalid = 1'b0; end
            SSEG_SEG_1:     begin code = 4'd1;            invalid = 1'b0; end
            SSEG_SEG_2:     begin code = 4'd2;            invalid = 1'b0; end
            SSEG_SEG_3:     begin code = 4'd3;            invalid = 1'b0; end
            SSEG_SEG_4:     begin code = 4'd4;            invalid = 1'b0; end
            SSEG_SEG_5:     begin code = 4'd5;            invalid = 1'b0; end
            SSEG_SEG_6:     begin code = 4'd6;            invalid = 1'b0; end
            SSEG_SEG_7:     begin code = 4'd7;            invalid = 1'b0; end
            SSEG_SEG_8:     begin code = 4'd8;            invalid = 1'b0; end
            SSEG_SEG_9:     begin code = 4'd9;            invalid = 1'b0; end
            SSEG_SEG_BLANK: begin code = SSEG_BLANK_CODE; invalid = 1'b0; end
            default:        begin code = SSEG_BAD_CODE;   invalid = 1'b1; end
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus, captures each settled digit position
// and emits complete frames on a valid/ready port with overrun reporting.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [7:0]              cathode,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic [NUM_DIGITS-1:0]   frame_dp,
    output logic [NUM_DIGITS-1:0]   frame_invalid,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int              IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              CNT_W       = $clog2(NUM_DIGITS + 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] MASK_FULL = {NUM_DIGITS{1'b1}};

    logic [NUM_DIGITS-1:0] anode_meta, anode_sync, anode_prev;
    logic [7:0]            cathode_meta, cathode_sync, cathode_prev;

    // Two-flop synchronisers plus a one-cycle history used for the stability check.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_meta   <= '1;
            anode_sync   <= '1;
            anode_prev   <= '1;
            cathode_meta <= '1;
            cathode_sync <= '1;
            cathode_prev <= '1;
        end else begin
            anode_meta   <= anode;
            anode_sync   <= anode_meta;
            anode_prev   <= anode_sync;
            cathode_meta <= cathode;
            cathode_sync <= cathode_meta;
            cathode_prev <= cathode_sync;
        end
    end

    logic [CNT_W-1:0] low_count;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             pair_equal;

    always_comb begin
        low_count = '0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode_sync[i]) begin
                low_count = low_count + 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        sel_valid  = (low_count == CNT_W'(1));
        pair_equal = (anode_sync == anode_prev) && (cathode_sync == cathode_prev);
    end

    logic [3:0] dec_code;
    logic       dec_dp;
    logic       dec_invalid;

    sseg_pattern_decode u_decode (
        .cathode (cathode_sync),
        .code    (dec_code),
        .dp      (dec_dp),
        .invalid (dec_invalid)
    );

    scan_state_t state, state_nxt;
    logic [7:0]  stable_cnt, stable_cnt_nxt;
    logic        capture;

    always_comb begin
        state_nxt      = state;
        stable_cnt_nxt = stable_cnt;
        capture        = 1'b0;
        case (state)
            WAIT_SEL: begin
                stable_cnt_nxt = '0;
                if (sel_valid) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!sel_valid) begin
                    state_nxt      = WAIT_SEL;
                    stable_cnt_nxt = '0;
                end else if (!pair_equal) begin
                    stable_cnt_nxt = '0;
                end else if (stable_cnt == SETTLE_LAST) begin
                    capture        = 1'b1;
                    state_nxt      = HELD;
                    stable_cnt_nxt = '0;
                end else begin
                    stable_cnt_nxt = stable_cnt + 8'd1;
                end
            end
            HELD: begin
                if (!pair_equal) begin
                    state_nxt      = sel_valid ? SETTLE : WAIT_SEL;
                    stable_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt      = WAIT_SEL;
                stable_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_SEL;
            stable_cnt <= '0;
        end else begin
            state      <= state_nxt;
            stable_cnt <= stable_cnt_nxt;
        end
    end

    logic [4*NUM_DIGITS-1:0] slot_digits, slot_digits_nxt;
    logic [NUM_DIGITS-1:0]   slot_dp, slot_dp_nxt;
    logic [NUM_DIGITS-1:0]   slot_inv, slot_inv_nxt;
    logic [NUM_DIGITS-1:0]   mask, mask_nxt;
    logic                    frame_done;
    logic                    frame_load;

    // The slot image including this edge's capture, so completion can forward it straight out.
    always_comb begin
        slot_digits_nxt = slot_digits;
        slot_dp_nxt     = slot_dp;
        slot_inv_nxt    = slot_inv;
        mask_nxt        = mask;
        if (capture) begin
            slot_digits_nxt[4*sel_idx +: 4] = dec_code;
            slot_dp_nxt[sel_idx]            = dec_dp;
            slot_inv_nxt[sel_idx]           = dec_invalid;
            mask_nxt[sel_idx]               = 1'b1;
        end
        frame_done = capture && (mask_nxt == MASK_FULL);
        frame_load = frame_done && (!frame_valid || frame_ready);
    end

    // NOTE: slot storage has no reset; the mask alone says which slots hold meaningful data.
    always_ff @(posedge clk) begin
        slot_digits <= slot_digits_nxt;
        slot_dp     <= slot_dp_nxt;
        slot_inv    <= slot_inv_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
        end else begin
            mask <= frame_done ? '0 : mask_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_digits  <= '0;
            frame_dp      <= '0;
            frame_invalid <= '0;
            frame_valid   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= frame_done && frame_valid && !frame_ready;
            if (frame_load) begin
                frame_digits  <= slot_digits_nxt;
                frame_dp      <= slot_dp_nxt;
                frame_invalid <= slot_inv_nxt;
                frame_valid   <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench: dwell-level display model predicts frames, a negedge monitor checks them.
module tb_sseg_scan_decoder;
    import sseg_pkg::*;

    localparam int ND   = 4;
    localparam int LONG = 14;

    localparam logic [6:0] DIGIT_PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] anode;
    logic [7:0]    cathode;
    logic [4*ND-1:0] frame_digits;
    logic [ND-1:0] frame_dp;
    logic [ND-1:0] frame_invalid;
    logic          frame_valid;
    logic          frame_ready;
    logic          overrun;

    always #5 clk = ~clk;

    sseg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .anode         (anode),
        .cathode       (cathode),
        .frame_digits  (frame_digits),
        .frame_dp      (frame_dp),
        .frame_invalid (frame_invalid),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .overrun       (overrun)
    );

    typedef struct packed {
        logic [4*ND-1:0] digits;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   inv;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a dwell long enough to settle on exactly one position records that digit.
    logic [3:0]    m_code [ND];
    logic [ND-1:0] m_dp;
    logic [ND-1:0] m_inv;
    logic [ND-1:0] m_mask = '0;
    bit            hold_mode = 0;
    bit            hold_full = 0;
    int            exp_ovr   = 0;

    task automatic model_capture(input logic [ND-1:0] a, input logic [7:0] c);
        int     pos;
        frame_t f;
        if ($countones(~a) != 1) return;
        pos = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) pos = i;
        m_code[pos] = 4'hE;
        m_inv[pos]  = 1'b1;
        if (c[7:1] == 7'h7F) begin
            m_code[pos] = 4'hF;
            m_inv[pos]  = 1'b0;
        end
        for (int d = 0; d < 10; d++) begin
            if (c[7:1] == DIGIT_PAT[d]) begin
                m_code[pos] = 4'(d);
                m_inv[pos]  = 1'b0;
            end
        end
        m_dp[pos]   = ~c[0];
        m_mask[pos] = 1'b1;
        if (&m_mask) begin
            for (int i = 0; i < ND; i++) f.digits[4*i +: 4] = m_code[i];
            f.dp   = m_dp;
            f.inv  = m_inv;
            m_mask = '0;
            if (hold_mode && hold_full) begin
                exp_ovr++;
            end else begin
                exp_q.push_back(f);
                if (hold_mode) hold_full = 1;
            end
        end
    endtask

    // Called at posedge+2; returns at posedge+2.
    task automatic dwell(input logic [ND-1:0] a, input logic [7:0] c, input int n);
        anode   = a;
        cathode = c;
        if (n >= LONG) model_capture(a, c);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic scan(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                        input logic [7:0] c3, input int n);
        dwell(4'b1110, c0, n);
        dwell(4'b1101, c1, n);
        dwell(4'b1011, c2, n);
        dwell(4'b0111, c3, n);
    endtask

    function automatic logic [7:0] pat(input int d, input bit dp_on);
        return {DIGIT_PAT[d], ~dp_on};
    endfunction

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #2;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every consumed frame and the stability of a stalled frame.
    int     valid_cycles = 0;
    int     ovr_seen     = 0;
    frame_t held;
    bit     held_vld = 0;

    always @(negedge clk) begin
        frame_t cur;
        frame_t f;
        cur = {frame_digits, frame_dp, frame_invalid};
        if (rst) begin
            held_vld = 0;
        end else begin
            if (overrun) ovr_seen++;
            if (frame_valid) valid_cycles++;
            if (held_vld && frame_valid) check("hold_stable", 32'(cur), 32'(held));
            held_vld = frame_valid && !frame_ready;
            held     = cur;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %0h expected none (t=%0t)", cur, $time);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_digits", 32'(frame_digits), 32'(f.digits));
                    check("frame_dp", 32'(frame_dp), 32'(f.dp));
                    check("frame_invalid", 32'(frame_invalid), 32'(f.inv));
                end
            end
        end
    end

    initial begin
        int            v0;
        int            o0;
        logic [ND-1:0] last_a;
        logic [7:0]    last_c;
        logic [ND-1:0] a;
        logic [7:0]    c;
        int            n;

        rst         = 1'b1;
        anode       = '1;
        cathode     = '1;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_digits", 32'(frame_digits), 32'd0);
        check("rst_dp", 32'(frame_dp), 32'd0);
        check("rst_invalid", 32'(frame_invalid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        dwell(4'hF, 8'hFF, 10);

        // Plain scan, two passes: one frame per pass.
        v0 = valid_cycles;
        scan(pat(1, 0), pat(2, 0), pat(3, 0), pat(4, 0), 20);
        scan(pat(1, 0), pat(2, 0), pat(3, 0), pat(4, 0), 20);
        dwell(4'hF, 8'hFF, 20);
        drain("t1_drain");
        check("t1_valid_pulses", 32'(valid_cycles - v0), 32'd2);
        check("t1_digits", 32'(frame_digits), 32'h4321);

        // Dwells too short to settle.
        v0 = valid_cycles;
        scan(pat(5, 0), pat(6, 1), pat(7, 0), pat(8, 1), 4);
        scan(pat(5, 0), pat(6, 1), pat(7, 0), pat(8, 1), 4);
        dwell(4'hF, 8'hFF, 20);
        check("t2_no_valid", 32'(valid_cycles - v0), 32'd0);

        // Blank and illegal patterns.
        scan(8'b01101101, pat(5, 1), 8'b11111111, pat(7, 0), 20);
        dwell(4'hF, 8'hFF, 20);
        drain("t3_drain");
        check("t3_slot0_code", 32'(frame_digits[3:0]), 32'hE);
        check("t3_slot0_inv", 32'(frame_invalid[0]), 32'd1);
        check("t3_slot2_code", 32'(frame_digits[11:8]), 32'hF);
        check("t3_slot2_inv", 32'(frame_invalid[2]), 32'd0);

        // Stalled consumer across two scans.
        frame_ready = 1'b0;
        hold_mode   = 1;
        hold_full   = 0;
        o0          = ovr_seen;
        scan(pat(9, 1), pat(0, 0), pat(2, 1), pat(6, 0), 20);
        scan(pat(3, 0), pat(8, 1), pat(1, 0), pat(5, 1), 20);
        dwell(4'hF, 8'hFF, 20);
        check("t4_overrun_count", 32'(ovr_seen - o0), 32'd1);
        check("t4_valid_held", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_drop", 32'(frame_valid), 32'd0);
        #1;
        hold_mode = 0;
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Two low anodes never select; a one-cycle glitch restarts settling.
        dwell(4'b1100, pat(8, 0), 50);
        check("t5_state", 32'(dut.state), 32'(WAIT_SEL));
        dwell(4'b1110, pat(6, 0), 3);
        dwell(4'b1110, pat(0, 0), 1);
        anode   = 4'b1110;
        cathode = pat(6, 0);
        model_capture(anode, cathode);
        repeat (5) @(posedge clk);
        #1;
        check("t5_glitch_delay", 32'(dut.mask[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_glitch_capture", 32'(dut.mask[0]), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        dwell(4'b1101, pat(1, 0), 20);
        dwell(4'b1011, pat(2, 0), 20);
        dwell(4'b0111, pat(3, 1), 20);
        dwell(4'hF, 8'hFF, 20);
        drain("t5_drain");

        // Reset mid-frame discards partial captures.
        dwell(4'b1110, pat(4, 0), 20);
        dwell(4'b1101, pat(5, 0), 20);
        dwell(4'b1011, pat(6, 0), 20);
        dwell(4'hF, 8'hFF, 10);
        rst    = 1'b1;
        m_mask = '0;
        #1;
        check("t6_rst_digits", 32'(frame_digits), 32'd0);
        check("t6_rst_valid", 32'(frame_valid), 32'd0);
        check("t6_rst_mask", 32'(dut.mask), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        v0  = valid_cycles;
        dwell(4'b0111, pat(7, 0), 20);
        dwell(4'hF, 8'hFF, 20);
        check("t6_partial_no_valid", 32'(valid_cycles - v0), 32'd0);
        scan(pat(9, 0), pat(8, 1), pat(7, 0), pat(6, 1), 20);
        dwell(4'hF, 8'hFF, 20);
        drain("t6_drain");
        check("t6_one_frame", 32'(valid_cycles - v0), 32'd1);

        // Randomised dwells: short ones never settle, long ones always do.
        last_a = 4'hF;
        last_c = 8'hFF;
        for (int t = 0; t < 300; t++) begin
            do begin
                n = $urandom_range(0, 99);
                if (n < 70)      a = ~(4'b0001 << $urandom_range(0, ND - 1));
                else if (n < 85) a = 4'hF;
                else             a = 4'($urandom);
                n = $urandom_range(0, 99);
                if (n < 50)      c = pat($urandom_range(0, 9), 1'($urandom));
                else if (n < 70) c = {7'h7F, 1'($urandom)};
                else             c = 8'($urandom);
            end while (a == last_a && c == last_c);
            n = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(LONG, LONG + 10);
            dwell(a, c, n);
            last_a = a;
            last_c = c;
        end
        dwell((last_a == 4'hF && last_c == 8'hFF) ? 4'hE : 4'hF, 8'hFF, 3);
        dwell(4'hF, 8'hFE, 30);
        drain("rand_drain");
        check("overrun_total", 32'(ovr_seen), 32'(exp_ovr));

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
